lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator in the MEM stage. It drives the data-memory request interface (op code, 11-bit byte address, write data, stall/enable) and consumes its 1-cycle-latency read data.
- It accepts one load/store request at a time from the pipeline.
- Aligned accesses are issued directly. Misaligned accesses are split: loads become two word reads merged and sign-extended; stores become a sequence of byte stores.
- It returns a single registered response and back-pressures the pipeline while busy.

Parameters:
- AW, 11, memory byte-address width. Bit AW-1 is the bank select; word index is bits AW-2:2.
- DW, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_op  in  3  LoadByte/LoadHalfWord/LoadWord/StoreByte/StoreHalfWord/StoreWord (shared mem.vh encodings)
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load result, sign-extended; 0 for stores
- resp_split  out  1  qualifies resp_valid; access was misaligned and split
- lsu_busy  out  1  state != IDLE; feeds the pipeline stall
- m_stall  out  1  memory stall; 1 means no access (cen deasserted)
- m_op  out  3  memory op code
- m_addr  out  AW  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after a load issue

Behaviour:
- Reset (synchronous, any state): state=IDLE, m_stall=1, m_op=LoadWord, m_addr=0, m_wdata=0, resp_valid=0, resp_rdata=0, resp_split=0.
  - Reset mid-operation aborts without a response. Byte stores already issued remain in memory.
- Misaligned conditions (off = addr[1:0]): LH with off=3; LW with off!=0. LB is never misaligned.
- FSM states: IDLE, ACC, RD, RESP.
  - IDLE -> ACC on accept; op, addr, wdata are latched.
  - Illegal op code: IDLE -> RESP directly with rdata=0, no memory access.
  - ACC: m_stall=0, m_op/m_addr/m_wdata driven from the current sub-access. m_stall=1 in every other state.
  - Store sub-access: done when count reaches its limit -> RESP, else ACC with next byte.
  - Load sub-access: ACC -> RD.
  - RD: m_addr and m_op held at the ACC values, because memory lane extraction uses the live address low bits. m_rdata is captured. Go to ACC for the second word, else RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready rises in the cycle after RESP.
- Latency (T = accept cycle):
  - Aligned load: issue T+1, capture T+2, resp T+3.
  - Aligned store: issue T+1, resp T+2.
  - Split load: ACC0 at T+1 (LoadWord, word address = addr with bits[1:0] cleared), RD0 T+2, ACC1 T+3 (addr+4), RD1 T+4, resp T+5.
  - Split store: N = 2 (half) or 4 (word) StoreByte ops on consecutive cycles T+1..T+N. Op i uses address addr+i and m_wdata[7:0] = req_wdata byte i. resp at T+N+1.
- Split-load merge: {w1,w0} >> (8*off). Take the low 16 bits (LH) or 32 bits (LW); sign-extend LH.
- Address arithmetic is modulo 2^AW. 0x7FF+1 wraps to 0x000. Crossing 0x3FF->0x400 changes bank; no special case is needed.
- Aligned loads pass m_rdata through unchanged; memory has already done lane select and sign extension.
- resp_rdata holds its value until the next response.
- req_valid during busy is ignored and must be held by the pipeline.

Decomposition:
- mem.vh (shared) holds:
  - the six op-code macros;
  - LSU state encodings;
  - LSU_IDLE_OP = LoadWord.
- One sub-module, lsu_load_merge: combinational. Inputs are w0, w1, off, op; output is the sign-extended result. It also contains the misalignment detect function.

Test Plan:
- Aligned LW at 0x010, mem word 0xDEADBEEF -> resp_valid at T+3, rdata=0xDEADBEEF, resp_split=0, one access with m_stall=0.
- Aligned LB at 0x013, word 0x80112233 -> rdata=0xFFFFFF80 at T+3; m_addr held at 0x013 during RD.
- Split LW at 0x3FE, words 0x3FC=0xAABBCCDD and 0x400=0x11223344 -> two LoadWord issues at 0x3FC and 0x400, rdata=0x3344AABB, resp_split=1 at T+5.
- Split SW at 0x7FD, wdata=0x44332211 -> StoreByte at 0x7FD/0x7FE/0x7FF/0x000 with m_wdata[7:0]=0x11/0x22/0x33/0x44. resp at T+5; readback LW at 0x7FC gives 0x332211xx and LW at 0x000 gives 0xxxxxxx44.
- Split LH at 0x023, bytes 0x23=0xFE and 0x24=0x80 -> rdata=0xFFFF80FE.
- rst asserted during the 3rd byte of a split SW -> next cycle IDLE, m_stall=1, no resp_valid. Bytes 0 and 1 written, bytes 2 and 3 unchanged. A new request is accepted normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit memory controller.
//
// Contents:
//   - memory op-code encodings shared by the pipeline and the data memory
//   - LSU FSM state encodings
//   - LSU_IDLE_OP, the op driven onto the memory bus whenever no access is issued
//   - small op classification helpers
package lsu_mem_ctrl_pkg;

    localparam logic [2:0] OP_LB = 3'd0;
    localparam logic [2:0] OP_LH = 3'd1;
    localparam logic [2:0] OP_LW = 3'd2;
    localparam logic [2:0] OP_SB = 3'd3;
    localparam logic [2:0] OP_SH = 3'd4;
    localparam logic [2:0] OP_SW = 3'd5;

    localparam logic [2:0] LSU_IDLE_OP = OP_LW;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ACC  = 2'd1,
        LSU_RD   = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // Codes 6 and 7 are unused and are answered without touching memory.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_SW);
    endfunction

    function automatic logic op_is_load(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_merge.sv
// Split-load merge and misalignment detection.
//
// Ports:
//   w0_i          first (lower-address) word of a split load
//   w1_i          second word of a split load
//   off_i         byte offset of the original access within its word
//   op_i          original op code
//   result_o      merged, sign-extended load result
//   misaligned_o  the access at this offset crosses a word boundary
module lsu_load_merge
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] w0_i,
    input  logic [DW-1:0] w1_i,
    input  logic [1:0]    off_i,
    input  logic [2:0]    op_i,
    output logic [DW-1:0] result_o,
    output logic          misaligned_o
);

    // Byte ops never cross a word; halves only cross from offset 3.
    // Stores follow the same rule as the matching loads.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_SH: mis = (off == 2'd3);
            OP_LW, OP_SW: mis = (off != 2'd0);
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

    logic [4:0]    shamt;
    logic [DW-1:0] shifted;

    // The two words form a little-endian 64-bit window; shifting by the
    // offset brings the first requested byte down to bit 0.
    always_comb begin
        shamt        = {off_i, 3'b000};
        shifted      = DW'({w1_i, w0_i} >> shamt);
        misaligned_o = is_misaligned(op_i, off_i);
        if (op_i == OP_LH) begin
            result_o = {{(DW-16){shifted[15]}}, shifted[15:0]};
        end else begin
            result_o = shifted;
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator.
//
// Accepts one load/store at a time from the pipeline, issues it to the
// 1-cycle-latency data memory, and returns one registered response.
// Misaligned loads become two word reads that are merged; misaligned
// stores become a run of byte stores.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               pipeline request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata         request op code, byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_split  one-cycle response pulse, load result, split flag
//   lsu_busy                          controller not idle (pipeline stall)
//   m_stall/m_op/m_addr/m_wdata       memory request (m_stall=1 means no access)
//   m_rdata                           memory read data, valid the cycle after a load issue
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_split,
    output logic          lsu_busy,
    output logic          m_stall,
    output logic [2:0]    m_op,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    lsu_state_e    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] w0_q, w0_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          split_q, split_d;

    logic          misaligned;
    logic          is_load;
    logic          last_byte;
    logic [DW-1:0] merged;
    logic [AW-1:0] word_base;
    logic [AW-1:0] sub_addr;
    logic [2:0]    sub_op;
    logic [DW-1:0] sub_wdata;

    lsu_load_merge #(
        .DW(DW)
    ) u_merge (
        .w0_i        (w0_q),
        .w1_i        (m_rdata),
        .off_i       (addr_q[1:0]),
        .op_i        (op_q),
        .result_o    (merged),
        .misaligned_o(misaligned)
    );

    // Current sub-access. Split loads walk the two covering words; split
    // stores walk the bytes one address at a time. Address sums wrap
    // naturally at the top of the AW-bit space.
    always_comb begin
        is_load   = op_is_load(op_q);
        last_byte = (cnt_q == ((op_q == OP_SH) ? 2'd1 : 2'd3));
        word_base = {addr_q[AW-1:2], 2'b00};
        sub_addr  = addr_q;
        sub_op    = op_q;
        sub_wdata = wdata_q;
        if (misaligned && is_load) begin
            sub_addr = word_base + AW'({cnt_q[0], 2'b00});
            sub_op   = OP_LW;
        end else if (misaligned) begin
            sub_addr  = addr_q + AW'(cnt_q);
            sub_op    = OP_SB;
            sub_wdata = {{(DW-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
        end
    end

    // Memory bus drive. Address and op stay valid through RD because the
    // memory picks its read lane from the live low address bits. Reset
    // forces the idle values immediately so an access in flight at reset
    // is not completed by the memory.
    always_comb begin
        m_stall = 1'b1;
        m_op    = LSU_IDLE_OP;
        m_addr  = '0;
        m_wdata = '0;
        if (!rst) begin
            if (state_q == LSU_ACC) begin
                m_stall = 1'b0;
                m_op    = sub_op;
                m_addr  = sub_addr;
                m_wdata = sub_wdata;
            end else if (state_q == LSU_RD) begin
                m_op   = sub_op;
                m_addr = sub_addr;
            end
        end
    end

    // Next-state logic. The response registers only change on entry to
    // RESP, so resp_rdata holds between responses.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        w0_d    = w0_q;
        rdata_d = rdata_q;
        split_d = split_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    if (op_is_legal(req_op)) begin
                        state_d = LSU_ACC;
                    end else begin
                        state_d = LSU_RESP;
                        rdata_d = '0;
                        split_d = 1'b0;
                    end
                end
            end
            LSU_ACC: begin
                if (is_load) begin
                    state_d = LSU_RD;
                end else if (misaligned && !last_byte) begin
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    state_d = LSU_RESP;
                    rdata_d = '0;
                    split_d = misaligned;
                end
            end
            LSU_RD: begin
                if (misaligned && (cnt_q == 2'd0)) begin
                    w0_d    = m_rdata;
                    cnt_d   = 2'd1;
                    state_d = LSU_ACC;
                end else begin
                    state_d = LSU_RESP;
                    rdata_d = misaligned ? merged : m_rdata;
                    split_d = misaligned;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            op_q    <= LSU_IDLE_OP;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 2'd0;
            w0_q    <= '0;
            rdata_q <= '0;
            split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            w0_q    <= w0_d;
            rdata_q <= rdata_d;
            split_q <= split_d;
        end
    end

    assign req_ready  = (state_q == LSU_IDLE);
    assign lsu_busy   = (state_q != LSU_IDLE);
    assign resp_valid = (state_q == LSU_RESP) && !rst;
    assign resp_rdata = rdata_q;
    assign resp_split = split_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-addressed, 1-cycle-latency
// data memory model that does its own lane select and sign extension.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [10:0] req_addr = 11'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_split;
    logic        lsu_busy;
    logic        m_stall;
    logic [2:0]  m_op;
    logic [10:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tAcc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_ctrl #(.AW(11), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_split(resp_split),
        .lsu_busy(lsu_busy),
        .m_stall(m_stall), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Memory model: little-endian bytes, read word registered at issue,
    // lane extraction from the live address/op during the following cycle.
    logic [7:0]  mem [0:2047];
    logic [31:0] rd_word = 32'd0;
    logic        pre_en = 1'b0;
    logic [10:0] pre_addr = 11'd0;
    logic [31:0] pre_data = 32'd0;
    logic [10:0] a1, a2, a3, wa;
    logic [31:0] rd_sh;

    assign a1 = m_addr + 11'd1;
    assign a2 = m_addr + 11'd2;
    assign a3 = m_addr + 11'd3;
    assign wa = {m_addr[10:2], 2'b00};

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr]         <= pre_data[7:0];
            mem[pre_addr + 11'd1] <= pre_data[15:8];
            mem[pre_addr + 11'd2] <= pre_data[23:16];
            mem[pre_addr + 11'd3] <= pre_data[31:24];
        end else if (!m_stall) begin
            case (m_op)
                OP_SB: mem[m_addr] <= m_wdata[7:0];
                OP_SH: begin
                    mem[m_addr] <= m_wdata[7:0];
                    mem[a1]     <= m_wdata[15:8];
                end
                OP_SW: begin
                    mem[m_addr] <= m_wdata[7:0];
                    mem[a1]     <= m_wdata[15:8];
                    mem[a2]     <= m_wdata[23:16];
                    mem[a3]     <= m_wdata[31:24];
                end
                default: rd_word <= {mem[wa + 11'd3], mem[wa + 11'd2], mem[wa + 11'd1], mem[wa]};
            endcase
        end
    end

    always_comb begin
        rd_sh = rd_word >> {m_addr[1:0], 3'b000};
        case (m_op)
            OP_LB:   m_rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
            OP_LH:   m_rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: m_rdata = rd_sh;
        endcase
    end

    // Access and response logs, sampled on the falling edge.
    typedef struct {
        int          cyc;
        logic [2:0]  op;
        logic [10:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        accq[$];
    int          rcyc[$];
    logic [31:0] rdat[$];
    logic        rspl[$];

    always @(negedge clk) begin
        if (!m_stall) accq.push_back('{cyc, m_op, m_addr, m_wdata});
        if (resp_valid) begin
            rcyc.push_back(cyc);
            rdat.push_back(resp_rdata);
            rspl.push_back(resp_split);
        end
    end

    function automatic logic [7:0] peek(input logic [10:0] a);
        return mem[a];
    endfunction

    task automatic poke(input logic [10:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Presents a request and holds it until accepted; tAcc is the accept cycle.
    task automatic issue(input logic [2:0] op, input logic [10:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(negedge clk); #1;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL accept_timeout got=%0b exp=1", req_ready); end
        tAcc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int base, output int rc, output logic [31:0] rd, output logic sp);
        int n;
        n = 0;
        rc = -1; rd = 'x; sp = 1'bx;
        while (rcyc.size() <= base && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (rcyc.size() <= base) begin
            bad++; $display("FAIL resp_timeout got=none exp=response within 20 cycles");
        end else begin
            rc = rcyc[base]; rd = rdat[base]; sp = rspl[base];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (m_stall !== 1'b1) begin bad++; $display("FAIL rst_m_stall got=%0h exp=1", m_stall); end
        total++; if (m_op !== OP_LW) begin bad++; $display("FAIL rst_m_op got=%0h exp=%0h", m_op, OP_LW); end
        total++; if (m_addr !== 11'h000) begin bad++; $display("FAIL rst_m_addr got=%0h exp=0", m_addr); end
        total++; if (m_wdata !== 32'h0) begin bad++; $display("FAIL rst_m_wdata got=%0h exp=0", m_wdata); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata got=%0h exp=0", resp_rdata); end
        total++; if (resp_split !== 1'b0) begin bad++; $display("FAIL rst_resp_split got=%0h exp=0", resp_split); end
        total++; if (lsu_busy !== 1'b0) begin bad++; $display("FAIL rst_lsu_busy got=%0h exp=0", lsu_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0h exp=1", req_ready); end
    endtask

    task automatic test_aligned_lw;
        int ab, rb, rc; logic [31:0] rd; logic sp;
        poke(11'h010, 32'hDEADBEEF);
        ab = accq.size(); rb = rcyc.size();
        issue(OP_LW, 11'h010, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 3) begin bad++; $display("FAIL lw_resp_cycle got=%0d exp=%0d", rc, tAcc + 3); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%0h exp=deadbeef", rd); end
        total++; if (sp !== 1'b0) begin bad++; $display("FAIL lw_split got=%0h exp=0", sp); end
        total++; if (accq.size() - ab !== 1) begin bad++; $display("FAIL lw_access_count got=%0d exp=1", accq.size() - ab); end
        total++; if (accq[ab].cyc !== tAcc + 1 || accq[ab].op !== OP_LW || accq[ab].addr !== 11'h010)
            begin bad++; $display("FAIL lw_issue got=cyc%0d op%0h a%0h exp=cyc%0d op%0h a010", accq[ab].cyc, accq[ab].op, accq[ab].addr, tAcc + 1, OP_LW); end
    endtask

    task automatic test_aligned_lb;
        int rb, rc; logic [31:0] rd; logic sp;
        poke(11'h010, 32'h80112233);
        rb = rcyc.size();
        issue(OP_LB, 11'h013, 32'h0);
        @(negedge clk); #1;
        total++; if (m_stall !== 1'b0) begin bad++; $display("FAIL lb_acc_stall got=%0h exp=0", m_stall); end
        @(negedge clk); #1;
        total++; if (m_addr !== 11'h013) begin bad++; $display("FAIL lb_rd_addr_held got=%0h exp=013", m_addr); end
        total++; if (m_op !== OP_LB) begin bad++; $display("FAIL lb_rd_op_held got=%0h exp=%0h", m_op, OP_LB); end
        total++; if (m_stall !== 1'b1) begin bad++; $display("FAIL lb_rd_stall got=%0h exp=1", m_stall); end
        total++; if (lsu_busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL lb_busy got=busy%0b ready%0b exp=busy1 ready0", lsu_busy, req_ready); end
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 3) begin bad++; $display("FAIL lb_resp_cycle got=%0d exp=%0d", rc, tAcc + 3); end
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%0h exp=ffffff80", rd); end
    endtask

    task automatic test_aligned_sw;
        int ab, rb, rc; logic [31:0] rd; logic sp;
        ab = accq.size(); rb = rcyc.size();
        issue(OP_SW, 11'h040, 32'hCAFEF00D);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 2) begin bad++; $display("FAIL sw_resp_cycle got=%0d exp=%0d", rc, tAcc + 2); end
        total++; if (rd !== 32'h0 || sp !== 1'b0) begin bad++; $display("FAIL sw_resp got=rdata%0h split%0b exp=rdata0 split0", rd, sp); end
        total++; if (accq.size() - ab !== 1) begin bad++; $display("FAIL sw_access_count got=%0d exp=1", accq.size() - ab); end
        total++; if (accq[ab].op !== OP_SW || accq[ab].wdata !== 32'hCAFEF00D)
            begin bad++; $display("FAIL sw_issue got=op%0h d%0h exp=op%0h dcafef00d", accq[ab].op, accq[ab].wdata, OP_SW); end
        total++; if ({peek(11'h043), peek(11'h042), peek(11'h041), peek(11'h040)} !== 32'hCAFEF00D)
            begin bad++; $display("FAIL sw_mem got=%0h exp=cafef00d", {peek(11'h043), peek(11'h042), peek(11'h041), peek(11'h040)}); end
    endtask

    task automatic test_lh_inword;
        int rb, rc; logic [31:0] rd; logic sp;
        poke(11'h050, 32'h00800100);
        rb = rcyc.size();
        issue(OP_LH, 11'h051, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 3) begin bad++; $display("FAIL lh1_resp_cycle got=%0d exp=%0d", rc, tAcc + 3); end
        total++; if (rd !== 32'hFFFF8001 || sp !== 1'b0) begin bad++; $display("FAIL lh1_resp got=rdata%0h split%0b exp=rdataffff8001 split0", rd, sp); end
    endtask

    task automatic test_split_lw;
        int ab, rb, rc; logic [31:0] rd; logic sp;
        poke(11'h3FC, 32'hAABBCCDD);
        poke(11'h400, 32'h11223344);
        ab = accq.size(); rb = rcyc.size();
        issue(OP_LW, 11'h3FE, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 5) begin bad++; $display("FAIL slw_resp_cycle got=%0d exp=%0d", rc, tAcc + 5); end
        total++; if (rd !== 32'h3344AABB) begin bad++; $display("FAIL slw_rdata got=%0h exp=3344aabb", rd); end
        total++; if (sp !== 1'b1) begin bad++; $display("FAIL slw_split got=%0h exp=1", sp); end
        total++; if (accq.size() - ab !== 2) begin bad++; $display("FAIL slw_access_count got=%0d exp=2", accq.size() - ab); end
        total++; if (accq[ab].cyc !== tAcc + 1 || accq[ab].op !== OP_LW || accq[ab].addr !== 11'h3FC)
            begin bad++; $display("FAIL slw_issue0 got=cyc%0d op%0h a%0h exp=cyc%0d op%0h a3fc", accq[ab].cyc, accq[ab].op, accq[ab].addr, tAcc + 1, OP_LW); end
        total++; if (accq[ab+1].cyc !== tAcc + 3 || accq[ab+1].op !== OP_LW || accq[ab+1].addr !== 11'h400)
            begin bad++; $display("FAIL slw_issue1 got=cyc%0d op%0h a%0h exp=cyc%0d op%0h a400", accq[ab+1].cyc, accq[ab+1].op, accq[ab+1].addr, tAcc + 3, OP_LW); end
    endtask

    task automatic test_split_lh;
        int rb, rc; logic [31:0] rd; logic sp;
        poke(11'h020, 32'hFE000000);
        poke(11'h024, 32'h00000080);
        rb = rcyc.size();
        issue(OP_LH, 11'h023, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 5) begin bad++; $display("FAIL slh_resp_cycle got=%0d exp=%0d", rc, tAcc + 5); end
        total++; if (rd !== 32'hFFFF80FE || sp !== 1'b1) begin bad++; $display("FAIL slh_resp got=rdata%0h split%0b exp=rdataffff80fe split1", rd, sp); end
    endtask

    task automatic test_back_to_back;
        int ab, rb, rc, rc0; logic [31:0] rd; logic sp;
        rb = rcyc.size();
        issue(OP_LW, 11'h010, 32'h0);
        wait_resp(rb, rc0, rd, sp);
        total++; if (rd !== 32'h80112233) begin bad++; $display("FAIL b2b_lw_rdata got=%0h exp=80112233", rd); end
        ab = accq.size(); rb = rcyc.size();
        issue(3'd7, 11'h123, 32'h0);
        total++; if (tAcc !== rc0 + 1) begin bad++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", tAcc, rc0 + 1); end
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 1) begin bad++; $display("FAIL illegal_resp_cycle got=%0d exp=%0d", rc, tAcc + 1); end
        total++; if (rd !== 32'h0 || sp !== 1'b0) begin bad++; $display("FAIL illegal_resp got=rdata%0h split%0b exp=rdata0 split0", rd, sp); end
        total++; if (accq.size() - ab !== 0) begin bad++; $display("FAIL illegal_access_count got=%0d exp=0", accq.size() - ab); end
    endtask

    task automatic test_split_sw;
        int ab, rb, rc; logic [31:0] rd; logic sp;
        logic [10:0] expA [4];
        logic [7:0]  expB [4];
        expA = '{11'h7FD, 11'h7FE, 11'h7FF, 11'h000};
        expB = '{8'h11, 8'h22, 8'h33, 8'h44};
        poke(11'h7FC, 32'h000000CC);
        poke(11'h000, 32'h99887700);
        ab = accq.size(); rb = rcyc.size();
        issue(OP_SW, 11'h7FD, 32'h44332211);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 5) begin bad++; $display("FAIL ssw_resp_cycle got=%0d exp=%0d", rc, tAcc + 5); end
        total++; if (rd !== 32'h0 || sp !== 1'b1) begin bad++; $display("FAIL ssw_resp got=rdata%0h split%0b exp=rdata0 split1", rd, sp); end
        total++; if (accq.size() - ab !== 4) begin bad++; $display("FAIL ssw_access_count got=%0d exp=4", accq.size() - ab); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (accq[ab+i].cyc !== tAcc + 1 + i || accq[ab+i].op !== OP_SB || accq[ab+i].addr !== expA[i] || accq[ab+i].wdata[7:0] !== expB[i])
                begin bad++; $display("FAIL ssw_byte%0d got=cyc%0d op%0h a%0h d%0h exp=cyc%0d op%0h a%0h d%0h", i, accq[ab+i].cyc, accq[ab+i].op, accq[ab+i].addr, accq[ab+i].wdata[7:0], tAcc + 1 + i, OP_SB, expA[i], expB[i]); end
        end
        rb = rcyc.size();
        issue(OP_LW, 11'h7FC, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rd !== 32'h332211CC) begin bad++; $display("FAIL ssw_readback_7fc got=%0h exp=332211cc", rd); end
        rb = rcyc.size();
        issue(OP_LW, 11'h000, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rd !== 32'h99887744) begin bad++; $display("FAIL ssw_readback_000 got=%0h exp=99887744", rd); end
    endtask

    task automatic test_reset_mid_sw;
        int ab, rb, rc; logic [31:0] rd; logic sp;
        poke(11'h100, 32'hA5A5A5A5);
        poke(11'h104, 32'h5A5A5A5A);
        ab = accq.size(); rb = rcyc.size();
        issue(OP_SW, 11'h101, 32'h44332211);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if (m_stall !== 1'b1) begin bad++; $display("FAIL midrst_stall_in_reset got=%0h exp=1", m_stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (lsu_busy !== 1'b0 || req_ready !== 1'b1 || m_stall !== 1'b1)
            begin bad++; $display("FAIL midrst_idle got=busy%0b ready%0b stall%0b exp=busy0 ready1 stall1", lsu_busy, req_ready, m_stall); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata_cleared got=%0h exp=0", resp_rdata); end
        repeat (3) begin @(negedge clk); #1; end
        total++; if (rcyc.size() !== rb) begin bad++; $display("FAIL midrst_no_resp got=%0d exp=%0d", rcyc.size(), rb); end
        total++; if (accq.size() - ab !== 2) begin bad++; $display("FAIL midrst_access_count got=%0d exp=2", accq.size() - ab); end
        total++; if ({peek(11'h104), peek(11'h103), peek(11'h102), peek(11'h101)} !== 32'h5AA52211)
            begin bad++; $display("FAIL midrst_mem got=%0h exp=5aa52211", {peek(11'h104), peek(11'h103), peek(11'h102), peek(11'h101)}); end
        rb = rcyc.size();
        issue(OP_LW, 11'h100, 32'h0);
        wait_resp(rb, rc, rd, sp);
        total++; if (rc !== tAcc + 3) begin bad++; $display("FAIL midrst_next_cycle got=%0d exp=%0d", rc, tAcc + 3); end
        total++; if (rd !== 32'hA52211A5) begin bad++; $display("FAIL midrst_next_rdata got=%0h exp=a52211a5", rd); end
    endtask

    initial begin
        test_reset();
        test_aligned_lw();
        test_aligned_lb();
        test_aligned_sw();
        test_lh_inword();
        test_split_lw();
        test_split_lh();
        test_back_to_back();
        test_split_sw();
        test_reset_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
